mc_muldiv_unit: RTL and testbench
=================================

// Module: mc_muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit with HI/LO registers for the multicycle MIPS datapath.
//   Executes MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes.
//   Sits beside the ALU: operands come from the A/B operand registers, and HI/LO feed the RF write-data mux.
//   The control FSM raises start_i and then holds in a wait state until done_o.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous reset, active-high
//   start_i        in   1      start request; accepted only in IDLE or DONE
//   op_i           in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
//   rs_i           in   WIDTH  multiplicand / dividend; sampled with start
//   rt_i           in   WIDTH  multiplier / divisor; sampled with start
//   hi_we_i        in   1      MTHI write strobe
//   lo_we_i        in   1      MTLO write strobe
//   wdata_i        in   WIDTH  MTHI/MTLO data
//   busy_o         out  1      high in RUN and FIX
//   done_o         out  1      one-cycle completion pulse (state DONE)
//   div_by_zero_o  out  1      last completed divide had rt=0
//   hi_o           out  WIDTH  HI register
//   lo_o           out  WIDTH  LO register
// BEHAVIOUR
//   Reset (sync, overrides all): state=IDLE; hi_o=lo_o=0; busy_o=done_o=div_by_zero_o=0; operand/work regs cleared.
//   Reset mid-RUN aborts the operation; no partial result reaches HI/LO.
//   FSM: IDLE -start-> RUN; RUN -(WIDTH iterations)-> FIX; FIX -> DONE; DONE -start-> RUN, else -> IDLE.
//   Accept at edge E0: latch |rs|,|rt| (signed ops take magnitudes) and the result signs; clear count; clear div_by_zero_o.
//   RUN: edges E1..E_WIDTH each perform one radix-2 step.
//     MUL: shift-add into a 2*WIDTH accumulator.
//     DIV: restoring shift-subtract; quotient and remainder each WIDTH bits.
//   FIX at edge E_WIDTH+1: apply sign correction, then write HI/LO.
//     MUL: {HI,LO} = 2*WIDTH-bit product, negated if operand signs differ.
//     DIV: LO = quotient, negated if signs differ; HI = remainder, carrying the sign of the dividend.
//   done_o is high for exactly the one cycle after E_WIDTH+1 (WIDTH+2 edges after accept); HI/LO are valid in that cycle.
//   Divide by zero: same latency; HI=rs_i, LO={WIDTH{1'b1}}, no sign fix; div_by_zero_o=1 with done_o.
//     div_by_zero_o holds until the next accepted start.
//   Signed overflow (MIN / -1): LO=MIN, HI=0; no flag.
//   start_i while busy_o=1 is ignored. start_i in DONE is accepted (back-to-back, no IDLE bubble).
//   hi_we_i/lo_we_i apply at the next edge in IDLE or DONE; they are dropped while busy_o=1.
//     A write in the same cycle as an accepted start is applied, then overwritten at FIX.
//   Operand inputs are don't-care after the accept edge.
//   Only WIDTH-bit unsigned and two's-complement arithmetic; no truncation except as defined above.
// TESTING (WIDTH=32)
//   1. MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o high exactly 34 edges after accept, for 1 cycle.
//   2. MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//      MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//   3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIVU 7/2 -> LO=3, HI=1.
//      DIV 7/-2 -> LO=0xFFFFFFFD, HI=1.
//   4. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero_o=0.
//      DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, div_by_zero_o=1 until next start.
//   5. Protocol:
//      start pulse mid-RUN -> ignored, result unchanged.
//      hi_we_i mid-RUN -> dropped.
//      MTLO 0x1234 in IDLE -> lo_o=0x1234 next cycle.
//      start in DONE cycle -> new op accepted, done_o 34 edges later.
//   6. Reset asserted at iteration 10 of a DIV -> next cycle busy_o=0, hi_o=lo_o=0; a following MULTU 6*7 -> LO=42, HI=0.

Source files
------------

// File: rtl/mc_muldiv_unit.sv
// mc_muldiv_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
// Handles MULTU/MULT/DIVU/DIV over WIDTH cycles plus MTHI/MTLO writes.
// Handshake: start_i is taken only when busy_o=0 (IDLE or DONE); busy_o stays
// high through RUN and FIX; done_o pulses for one cycle with HI/LO valid.
module mc_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   rs_q, rs_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               busy;
   logic               accept;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_abs, rt_abs;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quot_fixed, rem_fixed;

   // Operand magnitudes and one radix-2 step for each operation.
   // acc holds {partial product, remaining multiplier} for MUL and
   // {partial remainder, dividend/quotient bits} for DIV; b holds the
   // multiplicand or divisor magnitude.
   always_comb begin
      busy   = (state_q == S_RUN) || (state_q == S_FIX);
      accept = start_i && !busy;
      rs_neg = op_i[0] & rs_i[WIDTH-1];
      rt_neg = op_i[0] & rt_i[WIDTH-1];
      rs_abs = rs_neg ? (~rs_i + 1'b1) : rs_i;
      rt_abs = rt_neg ? (~rt_i + 1'b1) : rt_i;

      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Remainder stays below the divisor, so a failed subtract leaves a
      // shifted value that still fits in WIDTH bits.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

      prod_fixed = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      quot_fixed = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fixed  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   // Control FSM, operand capture, iteration and HI/LO update.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_d       = b_q;
      rs_d      = rs_q;
      acc_d     = acc_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;

      // MTHI/MTLO land whenever the unit is not busy, including the accept cycle.
      if (!busy && hi_we_i) hi_d = wdata_i;
      if (!busy && lo_we_i) lo_d = wdata_i;

      case (state_q)
         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fixed;
            end else if (b_q == '0) begin
               hi_d  = rs_q;
               lo_d  = {WIDTH{1'b1}};
               dbz_d = 1'b1;
            end else begin
               hi_d = rem_fixed;
               lo_d = quot_fixed;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         state_d   = S_RUN;
         cnt_d     = '0;
         is_div_d  = op_i[1];
         neg_res_d = rs_neg ^ rt_neg;
         neg_rem_d = op_i[1] & rs_neg;
         rs_d      = rs_i;
         b_d       = op_i[1] ? rt_abs : rs_abs;
         acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? rs_abs : rt_abs)};
         dbz_d     = 1'b0;
      end
   end

   // State registers with synchronous reset that aborts any operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_q       <= '0;
         rs_q      <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_q       <= b_d;
         rs_q      <= rs_d;
         acc_q     <= acc_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy_o        = busy;
   assign done_o        = (state_q == S_DONE);
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Directed testbench for mc_muldiv_unit (WIDTH=32) with hand-computed results.
module tb_mc_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] rs_i;
   logic [31:0] rt_i;
   logic        hi_we_i;
   logic        lo_we_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic        div_by_zero_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   mc_muldiv_unit #(.WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .op_i          (op_i),
      .rs_i          (rs_i),
      .rt_i          (rt_i),
      .hi_we_i       (hi_we_i),
      .lo_we_i       (lo_we_i),
      .wdata_i       (wdata_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .div_by_zero_o (div_by_zero_o),
      .hi_o          (hi_o),
      .lo_o          (lo_o)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait for done_o. Edge count includes the accept
   // edge, so done_o becomes visible after 34 edges. Optionally pokes a stray
   // start or an MTHI write while the unit is busy.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, input bit poke_start, input bit poke_hi);
      int n_edges;
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
      rs_i    = a;
      rt_i    = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      op_i    = 2'($urandom_range(0, 3));
      rs_i    = $urandom;
      rt_i    = $urandom;
      check_eq("busy_after_accept", {63'd0, busy_o}, 64'd1);
      check_eq("dbz_clear_on_accept", {63'd0, div_by_zero_o}, 64'd0);
      n_edges = 1;
      while (!done_o && n_edges < 100) begin
         if (n_edges == poke_at) begin
            start_i = poke_start;
            op_i    = OP_MULTU;
            rs_i    = 32'hFFFF_FFFF;
            rt_i    = 32'hFFFF_FFFF;
            hi_we_i = poke_hi;
            wdata_i = 32'hDEAD_BEEF;
         end else begin
            start_i = 1'b0;
            hi_we_i = 1'b0;
         end
         @(posedge clk);
         #1;
         n_edges++;
      end
      start_i = 1'b0;
      hi_we_i = 1'b0;
      check_eq("done_latency", 64'(n_edges), 64'd34);
   endtask

   initial begin
      reset   = 1'b1;
      start_i = 1'b0;
      op_i    = 2'b00;
      rs_i    = '0;
      rt_i    = '0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      wdata_i = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      check_eq("rst_hi",   {32'd0, hi_o}, 64'd0);
      check_eq("rst_lo",   {32'd0, lo_o}, 64'd0);
      check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
      check_eq("rst_done", {63'd0, done_o}, 64'd0);
      check_eq("rst_dbz",  {63'd0, div_by_zero_o}, 64'd0);

      // MULTU max*max, done pulse width
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      check_eq("multu_max", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
      check_eq("done_high", {63'd0, done_o}, 64'd1);
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", {63'd0, done_o}, 64'd0);
      check_eq("idle_not_busy", {63'd0, busy_o}, 64'd0);

      // Signed multiplies (back-to-back from DONE from here on)
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0);
      check_eq("mult_neg3x7", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b0);
      check_eq("mult_min_sq", {hi_o, lo_o}, 64'h4000_0000_0000_0000);

      // Divides
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
      check_eq("div_neg7_2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIVU, 32'd7, 32'd2, 0, 1'b0, 1'b0);
      check_eq("divu_7_2", {hi_o, lo_o}, 64'h0000_0001_0000_0003);
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, 1'b0);
      check_eq("div_7_neg2", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFD);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      check_eq("div_min_neg1", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
      check_eq("div_min_neg1_dbz", {63'd0, div_by_zero_o}, 64'd0);

      // Divide by zero, flag persists while idle
      run_op(OP_DIVU, 32'd5, 32'd0, 0, 1'b0, 1'b0);
      check_eq("divu_by_zero", {hi_o, lo_o}, 64'h0000_0005_FFFF_FFFF);
      check_eq("dbz_with_done", {63'd0, div_by_zero_o}, 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("dbz_held", {63'd0, div_by_zero_o}, 64'd1);
      check_eq("dbz_idle_busy", {63'd0, busy_o}, 64'd0);

      // MTLO in IDLE
      @(negedge clk);
      lo_we_i = 1'b1;
      wdata_i = 32'h0000_1234;
      @(posedge clk);
      #1;
      lo_we_i = 1'b0;
      check_eq("mtlo_idle", {32'd0, lo_o}, 64'h1234);
      check_eq("mtlo_hi_kept", {32'd0, hi_o}, 64'd5);

      // Stray start mid-RUN is ignored (run_op also checks dbz cleared)
      run_op(OP_DIVU, 32'd100, 32'd7, 5, 1'b1, 1'b0);
      check_eq("start_mid_run", {hi_o, lo_o}, 64'h0000_0002_0000_000E);

      // MTHI strobe mid-RUN is dropped
      run_op(OP_MULTU, 32'd3, 32'd5, 10, 1'b0, 1'b1);
      check_eq("mthi_mid_run", {hi_o, lo_o}, 64'h0000_0000_0000_000F);

      // Reset after 10 iterations of a DIV
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b1;
      op_i    = OP_DIV;
      rs_i    = 32'hFFFF_FF9C;
      rt_i    = 32'd3;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("busy_before_abort", {63'd0, busy_o}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("abort_busy", {63'd0, busy_o}, 64'd0);
      check_eq("abort_hilo", {hi_o, lo_o}, 64'd0);
      check_eq("abort_done", {63'd0, done_o}, 64'd0);
      @(posedge clk);
      #1;
      check_eq("abort_no_late_done", {63'd0, done_o}, 64'd0);

      run_op(OP_MULTU, 32'd6, 32'd7, 0, 1'b0, 1'b0);
      check_eq("multu_after_abort", {hi_o, lo_o}, 64'd42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
